// File: rtl/ram_sync_init_if.sv
// Request/response bus of the synchronous init-on-reset RAM.
// The master issues requests; the slave (the RAM) returns one response per accepted request.
interface ram_sync_init_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    is_write;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] byte_en;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rdata_valid;
  logic                    init_done;

  modport master (
    output req_valid, is_write, address, wdata, byte_en,
    input  req_ready, rdata, rdata_valid, init_done
  );

  modport slave (
    input  req_valid, is_write, address, wdata, byte_en,
    output req_ready, rdata, rdata_valid, init_done
  );
endinterface

// File: rtl/ram_sync_init.sv
// Single-port synchronous RAM with byte enables, 1-cycle registered response and a
// clear sweep that writes INIT_VALUE to every word after each reset.
module ram_sync_init #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  ram_sync_init_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {INIT, READY} state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] cnt, cnt_d;
  logic                  sweep_we;
  logic                  fire;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] old_word, new_word;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rdata_valid_q;

  // Ready/done come straight from the state flop, so both are registered and rise together.
  assign bus.req_ready   = (state == READY);
  assign bus.init_done   = (state == READY);
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;

  assign fire     = bus.req_valid & bus.req_ready;
  assign old_word = mem[bus.address];

  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign new_word[8*i +: 8] = bus.byte_en[i] ? bus.wdata[8*i +: 8] : old_word[8*i +: 8];
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sweep_we = 1'b0;
    case (state)
      INIT: begin
        sweep_we = 1'b1;
        cnt_d    = cnt + ADDR_WIDTH'(1);
        if (cnt == {ADDR_WIDTH{1'b1}}) state_d = READY;
      end
      READY: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= INIT;
      cnt           <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      rdata_valid_q <= fire;
      if (fire) rdata_q <= bus.is_write ? new_word : old_word;
    end
  end

  // Storage has no reset; the sweep clears it, so no request can fire until it completes.
  always_ff @(posedge clk) begin
    if (sweep_we)
      mem[cnt] <= INIT_VALUE;
    else if (fire && bus.is_write)
      mem[bus.address] <= new_word;
  end
endmodule

// File: tb/tb_ram_sync_init.sv
// Directed bench for ram_sync_init (32-bit words, 16 lines): sweep timing, byte-enabled
// writes with echo, back-to-back read-after-write, requests during INIT and mid-run reset.
module tb_ram_sync_init;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ram_sync_init_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  ram_sync_init #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .INIT_VALUE(32'h0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [3:0] addr, input logic [31:0] data,
                     input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.is_write  = we;
    bus.address   = addr;
    bus.wdata     = data;
    bus.byte_en   = be;
    tick();
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    tick();
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] exp);
    check({tag, "_valid"}, {31'd0, bus.rdata_valid}, 32'd1);
    check({tag, "_data"},  bus.rdata, exp);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.is_write  = 1'b0;
    bus.address   = '0;
    bus.wdata     = '0;
    bus.byte_en   = '0;
    #3;
    check("rst_ready", {31'd0, bus.req_ready},   32'd0);
    check("rst_done",  {31'd0, bus.init_done},   32'd0);
    check("rst_valid", {31'd0, bus.rdata_valid}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);

    // Request held during the whole sweep must be ignored.
    bus.req_valid = 1'b1;
    bus.is_write  = 1'b1;
    bus.address   = 4'h3;
    bus.wdata     = 32'hFFFF_FFFF;
    bus.byte_en   = 4'hF;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("init_ready_%0d", i), {31'd0, bus.req_ready},   32'd0);
      check($sformatf("init_valid_%0d", i), {31'd0, bus.rdata_valid}, 32'd0);
      tick();
    end
    bus.req_valid = 1'b0;
    check("ready_after_sweep", {31'd0, bus.req_ready}, 32'd1);
    check("done_after_sweep",  {31'd0, bus.init_done}, 32'd1);
    check("no_pulse_init_end", {31'd0, bus.rdata_valid}, 32'd0);

    req(1'b0, 4'hF, 32'h0, 4'h0);  chk_resp("rd_F", 32'h0);
    req(1'b0, 4'h3, 32'h0, 4'h0);  chk_resp("rd_3_after_init", 32'h0);
    idle();
    check("idle_valid", {31'd0, bus.rdata_valid}, 32'd0);

    req(1'b1, 4'hC, 32'hE5F8_4AB1, 4'hF);  chk_resp("wr_C_full_echo", 32'hE5F8_4AB1);
    idle();
    check("idle_valid_2", {31'd0, bus.rdata_valid}, 32'd0);
    check("idle_hold",    bus.rdata, 32'hE5F8_4AB1);
    req(1'b0, 4'hC, 32'h0, 4'h0);  chk_resp("rd_C_full", 32'hE5F8_4AB1);

    req(1'b1, 4'hC, 32'h5C8C_6A01, 4'b0101);  chk_resp("wr_C_part_echo", 32'hE58C_4A01);
    req(1'b0, 4'hC, 32'h0, 4'h0);             chk_resp("rd_C_part", 32'hE58C_4A01);
    req(1'b1, 4'h6, 32'h1234_5678, 4'h0);     chk_resp("wr_6_be0_echo", 32'h0);

    req(1'b1, 4'hB, 32'h5C8C_6A01, 4'hF);  chk_resp("wr_B_echo", 32'h5C8C_6A01);
    req(1'b0, 4'hB, 32'h0, 4'h0);          chk_resp("rd_B_b2b", 32'h5C8C_6A01);
    req(1'b0, 4'hC, 32'h0, 4'h0);          chk_resp("rd_C_noalias", 32'hE58C_4A01);
    idle();
    check("idle_valid_3", {31'd0, bus.rdata_valid}, 32'd0);

    // Reset pulse between edges with a read response outstanding.
    req(1'b0, 4'hC, 32'h0, 4'h0);
    bus.req_valid = 1'b0;
    chk_resp("rd_C_before_rst", 32'hE58C_4A01);
    reset_n = 1'b0;
    #1;
    check("midrst_rdata", bus.rdata, 32'd0);
    check("midrst_valid", {31'd0, bus.rdata_valid}, 32'd0);
    check("midrst_ready", {31'd0, bus.req_ready},   32'd0);
    check("midrst_done",  {31'd0, bus.init_done},   32'd0);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("resweep_ready_%0d", i), {31'd0, bus.req_ready}, 32'd0);
      tick();
    end
    check("ready_after_resweep", {31'd0, bus.req_ready}, 32'd1);
    req(1'b0, 4'hB, 32'h0, 4'h0);  chk_resp("rd_B_cleared", 32'h0);
    req(1'b0, 4'hC, 32'h0, 4'h0);  chk_resp("rd_C_cleared", 32'h0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
